// File: rtl/ifft_dif_butterfly_pipe_pkg.sv
// Shared FFT definitions: default widths, the twiddle unity constant and a
// complex sample type used by the butterfly datapath and its environment.
package fft_pkg;

   localparam int DEF_DATA_WIDTH = 21;
   localparam int DEF_FRAC_BITS  = 15;
   localparam int MUL_W          = 2 * DEF_DATA_WIDTH;
   localparam int TWID_ONE       = 1 << DEF_FRAC_BITS;

   typedef struct packed {
      logic signed [DEF_DATA_WIDTH-1:0] re;
      logic signed [DEF_DATA_WIDTH-1:0] im;
   } cplx_t;

endpackage

// File: rtl/ifft_dif_butterfly_pipe_if.sv
// Streaming bus of the IFFT DIF butterfly: operand set in with valid/ready,
// A/B results out with valid/ready. The master side is the surrounding
// stage logic, the slave side is the butterfly itself.
interface ifft_dif_butterfly_pipe_if #(
   parameter int DATA_WIDTH = fft_pkg::DEF_DATA_WIDTH
);

   logic                         valid_i;
   logic                         ready_o;
   logic signed [DATA_WIDTH-1:0] a_re_i;
   logic signed [DATA_WIDTH-1:0] a_im_i;
   logic signed [DATA_WIDTH-1:0] b_re_i;
   logic signed [DATA_WIDTH-1:0] b_im_i;
   logic signed [DATA_WIDTH-1:0] twid_re_i;
   logic signed [DATA_WIDTH-1:0] twid_im_i;
   logic                         valid_o;
   logic                         ready_i;
   logic signed [DATA_WIDTH-1:0] a_re_o;
   logic signed [DATA_WIDTH-1:0] a_im_o;
   logic signed [DATA_WIDTH-1:0] b_re_o;
   logic signed [DATA_WIDTH-1:0] b_im_o;

   modport master (
      output valid_i, a_re_i, a_im_i, b_re_i, b_im_i, twid_re_i, twid_im_i, ready_i,
      input  ready_o, valid_o, a_re_o, a_im_o, b_re_o, b_im_o
   );

   modport slave (
      input  valid_i, a_re_i, a_im_i, b_re_i, b_im_i, twid_re_i, twid_im_i, ready_i,
      output ready_o, valid_o, a_re_o, a_im_o, b_re_o, b_im_o
   );

endinterface

// File: rtl/ifft_dif_butterfly_pipe_cplx_mul_conj.sv
// Conjugate complex multiplier y = d * conj(w) with one product register
// stage and one rounded output stage, both gated by a shared enable.
// Build option: BFLY_HALF_SCALE_EN adds an extra 1/2 to the output shift.
module cplx_mul_conj
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic signed [DATA_WIDTH:0]   d_re,
   input  logic signed [DATA_WIDTH:0]   d_im,
   input  logic signed [DATA_WIDTH-1:0] w_re,
   input  logic signed [DATA_WIDTH-1:0] w_im,
   output logic signed [DATA_WIDTH-1:0] y_re,
   output logic signed [DATA_WIDTH-1:0] y_im
);

   localparam int PROD_W = 2 * DATA_WIDTH + 1;
   localparam int ACC_W  = PROD_W + 1;
`ifdef BFLY_HALF_SCALE_EN
   localparam int SHIFT  = FRAC_BITS + 1;
`else
   localparam int SHIFT  = FRAC_BITS;
`endif
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);

   logic signed [PROD_W-1:0]     p_rr_p1, p_ii_p1, p_ir_p1, p_ri_p1;
   logic signed [ACC_W-1:0]      re_acc, im_acc;
   logic signed [DATA_WIDTH-1:0] y_re_p2, y_im_p2;

   function automatic logic signed [PROD_W-1:0] ext_d(input logic signed [DATA_WIDTH:0] x);
      return {{(PROD_W-DATA_WIDTH-1){x[DATA_WIDTH]}}, x};
   endfunction

   function automatic logic signed [PROD_W-1:0] ext_w(input logic signed [DATA_WIDTH-1:0] x);
      return {{(PROD_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
   endfunction

   // Round half up, arithmetic shift, then wrap to the output width.
   function automatic logic signed [DATA_WIDTH-1:0] round_shift(input logic signed [ACC_W-1:0] x);
      logic signed [ACC_W-1:0] t;
      t = (x + RND) >>> SHIFT;
      return t[DATA_WIDTH-1:0];
   endfunction

   // Stage 2 boundary: register the four partial products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_rr_p1 <= '0;
         p_ii_p1 <= '0;
         p_ir_p1 <= '0;
         p_ri_p1 <= '0;
      end else if (en) begin
         p_rr_p1 <= ext_d(d_re) * ext_w(w_re);
         p_ii_p1 <= ext_d(d_im) * ext_w(w_im);
         p_ir_p1 <= ext_d(d_im) * ext_w(w_re);
         p_ri_p1 <= ext_d(d_re) * ext_w(w_im);
      end
   end

   // Conjugate combine: re = dr*wr + di*wi, im = di*wr - dr*wi, at full width.
   always_comb begin
      re_acc = {p_rr_p1[PROD_W-1], p_rr_p1} + {p_ii_p1[PROD_W-1], p_ii_p1};
      im_acc = {p_ir_p1[PROD_W-1], p_ir_p1} - {p_ri_p1[PROD_W-1], p_ri_p1};
   end

   // Stage 3 boundary: register the rounded, truncated result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_re_p2 <= '0;
         y_im_p2 <= '0;
      end else if (en) begin
         y_re_p2 <= round_shift(re_acc);
         y_im_p2 <= round_shift(im_acc);
      end
   end

   assign y_re = y_re_p2;
   assign y_im = y_im_p2;

endmodule

// File: rtl/ifft_dif_butterfly_pipe.sv
// Pipelined radix-2 DIF (Gentleman-Sande) butterfly for the inverse FFT:
// A = a + b, B = (a - b) * conj(W). Three register stages under one global
// stall; bubbles travel with the data and are never collapsed.
// Build option: BFLY_HALF_SCALE_EN scales both outputs by 1/2 per stage.
module ifft_dif_butterfly_pipe
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   ifft_dif_butterfly_pipe_if.slave bus
);

   localparam int SUM_W = DATA_WIDTH + 1;

   logic                         stall, en;
   logic                         vld_p0, vld_p1, vld_p2;
   logic signed [SUM_W-1:0]      s_re_p0, s_im_p0, d_re_p0, d_im_p0;
   logic signed [SUM_W-1:0]      s_re_p1, s_im_p1;
   logic signed [DATA_WIDTH-1:0] w_re_p0, w_im_p0;
   logic signed [DATA_WIDTH-1:0] a_re_p2, a_im_p2, b_re_p2, b_im_p2;

`ifdef BFLY_HALF_SCALE_EN
   localparam logic signed [SUM_W:0] HALF_RND = (SUM_W + 1)'(1);

   // Sum path with half scaling: (s + 1) >>> 1, wrapped to the output width.
   function automatic logic signed [DATA_WIDTH-1:0] scale_sum(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W:0] t;
      t = {s[SUM_W-1], s};
      t = (t + HALF_RND) >>> 1;
      return t[DATA_WIDTH-1:0];
   endfunction
`else
   // Sum path without scaling: wrap to the output width.
   function automatic logic signed [DATA_WIDTH-1:0] scale_sum(input logic signed [SUM_W-1:0] s);
      return s[DATA_WIDTH-1:0];
   endfunction
`endif

   // A held result that is not being taken freezes the whole pipe.
   assign stall       = vld_p2 & ~bus.ready_i;
   assign en          = ~stall;
   assign bus.ready_o = en;

   // Valid flags advance in lockstep with the data stages.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (en) begin
         vld_p0 <= bus.valid_i;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   // Stage 1 boundary: one-bit-wider sum and difference, plus the twiddle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_re_p0 <= '0;
         s_im_p0 <= '0;
         d_re_p0 <= '0;
         d_im_p0 <= '0;
         w_re_p0 <= '0;
         w_im_p0 <= '0;
      end else if (en) begin
         s_re_p0 <= {bus.a_re_i[DATA_WIDTH-1], bus.a_re_i} + {bus.b_re_i[DATA_WIDTH-1], bus.b_re_i};
         s_im_p0 <= {bus.a_im_i[DATA_WIDTH-1], bus.a_im_i} + {bus.b_im_i[DATA_WIDTH-1], bus.b_im_i};
         d_re_p0 <= {bus.a_re_i[DATA_WIDTH-1], bus.a_re_i} - {bus.b_re_i[DATA_WIDTH-1], bus.b_re_i};
         d_im_p0 <= {bus.a_im_i[DATA_WIDTH-1], bus.a_im_i} - {bus.b_im_i[DATA_WIDTH-1], bus.b_im_i};
         w_re_p0 <= bus.twid_re_i;
         w_im_p0 <= bus.twid_im_i;
      end
   end

   // Stage 2 and 3 boundaries for the sum path, aligned with the multiplier.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_re_p1 <= '0;
         s_im_p1 <= '0;
         a_re_p2 <= '0;
         a_im_p2 <= '0;
      end else if (en) begin
         s_re_p1 <= s_re_p0;
         s_im_p1 <= s_im_p0;
         a_re_p2 <= scale_sum(s_re_p1);
         a_im_p2 <= scale_sum(s_im_p1);
      end
   end

   cplx_mul_conj #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_mul (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .en    (en),
      .d_re  (d_re_p0),
      .d_im  (d_im_p0),
      .w_re  (w_re_p0),
      .w_im  (w_im_p0),
      .y_re  (b_re_p2),
      .y_im  (b_im_p2)
   );

   assign bus.valid_o = vld_p2;
   assign bus.a_re_o  = a_re_p2;
   assign bus.a_im_o  = a_im_p2;
   assign bus.b_re_o  = b_re_p2;
   assign bus.b_im_o  = b_im_p2;

endmodule

// File: tb/tb_ifft_dif_butterfly_pipe.sv
// Bench for the IFFT DIF butterfly: directed cases, backpressure, mid-stream
// reset and a random stream against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ifft_dif_butterfly_pipe;
   import fft_pkg::*;

   localparam int W  = DEF_DATA_WIDTH;
   localparam int FB = DEF_FRAC_BITS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ifft_dif_butterfly_pipe_if #(.DATA_WIDTH(W)) bus ();

   ifft_dif_butterfly_pipe #(.DATA_WIDTH(W), .FRAC_BITS(FB)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      cplx_t a;
      cplx_t b;
   } exp_t;

   exp_t  exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    n_out = 0;
   bit    last_acc  = 1'b0;
   bit    hold_prev = 1'b0;
   logic [4*W-1:0] held;

   function automatic logic signed [W-1:0] trunc(input longint x);
      logic signed [W-1:0] r;
      r = x[W-1:0];
      return r;
   endfunction

   // Reference: exact integer arithmetic of the butterfly, then final wrap.
   function automatic exp_t model(input longint ar, ai, br, bi, wr, wi);
      longint sr, si, dr, di, pre, pim, sh;
      exp_t e;
      sr  = ar + br;
      si  = ai + bi;
      dr  = ar - br;
      di  = ai - bi;
      pre = dr * wr + di * wi;
      pim = di * wr - dr * wi;
`ifdef BFLY_HALF_SCALE_EN
      sr = (sr + 1) >>> 1;
      si = (si + 1) >>> 1;
      sh = FB + 1;
`else
      sh = FB;
`endif
      e.a.re = trunc(sr);
      e.a.im = trunc(si);
      e.b.re = trunc((pre + (longint'(1) << (sh - 1))) >>> sh);
      e.b.im = trunc((pim + (longint'(1) << (sh - 1))) >>> sh);
      return e;
   endfunction

   function automatic longint rnd_val();
      logic signed [W-1:0] r;
      r = W'($urandom);
      return longint'(r);
   endfunction

   function automatic longint rnd_twid();
      if ($urandom_range(0, 1) == 0) return longint'($urandom_range(0, 65536)) - 32768;
      return rnd_val();
   endfunction

   task automatic set_ops(input longint ar, ai, br, bi, wr, wi);
      bus.a_re_i    = trunc(ar);
      bus.a_im_i    = trunc(ai);
      bus.b_re_i    = trunc(br);
      bus.b_im_i    = trunc(bi);
      bus.twid_re_i = trunc(wr);
      bus.twid_im_i = trunc(wi);
   endtask

   // One clock: observe handshakes at the falling edge, return at posedge+1.
   task automatic tick();
      exp_t e;
      logic [4*W-1:0] outs;
      @(negedge clk);
      last_acc = 1'b0;
      outs = {bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o};
      n_cmp++;
      if (bus.ready_o !== !(bus.valid_o && !bus.ready_i)) begin
         n_err++;
         $display("FAIL ready_o: got %b want %b", bus.ready_o, !(bus.valid_o && !bus.ready_i));
      end
      if (hold_prev) begin
         n_cmp++;
         if (outs !== held || bus.valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL hold: got %h valid %b want %h valid 1", outs, bus.valid_o, held);
         end
      end
      if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL extra_output: got A=(%0d,%0d) B=(%0d,%0d) want no output",
                     bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o);
         end else begin
            e = exp_q.pop_front();
            n_out++;
            if (outs !== {e.a.re, e.a.im, e.b.re, e.b.im}) begin
               n_err++;
               $display("FAIL stream_data: got A=(%0d,%0d) B=(%0d,%0d) want A=(%0d,%0d) B=(%0d,%0d)",
                        bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o, e.a.re, e.a.im, e.b.re, e.b.im);
            end
         end
      end
      if (bus.valid_i === 1'b1 && bus.ready_o === 1'b1) begin
         exp_q.push_back(model(longint'(bus.a_re_i), longint'(bus.a_im_i),
                               longint'(bus.b_re_i), longint'(bus.b_im_i),
                               longint'(bus.twid_re_i), longint'(bus.twid_im_i)));
         last_acc = 1'b1;
      end
      hold_prev = bus.valid_o && !bus.ready_i;
      held      = outs;
      @(posedge clk);
      #1;
   endtask

   // Send one operand set into an empty pipe, check latency and result.
   task automatic send_one(input string name, input longint ar, ai, br, bi, wr, wi,
                           input longint ear, eai, ebr, ebi);
      int lat;
      set_ops(ar, ai, br, bi, wr, wi);
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b1;
      tick();
      bus.valid_i = 1'b0;
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      n_cmp++;
      if (lat != 3) begin
         n_err++;
         $display("FAIL %s_latency: got %0d cycles want 3", name, lat);
      end
      n_cmp++;
      if ({bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o} !== {trunc(ear), trunc(eai), trunc(ebr), trunc(ebi)}) begin
         n_err++;
         $display("FAIL %s: got A=(%0d,%0d) B=(%0d,%0d) want A=(%0d,%0d) B=(%0d,%0d)",
                  name, bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o, ear, eai, ebr, ebi);
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b0;
      set_ops(5, 6, 7, 8, 9, 10);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid: got %b want 0", bus.valid_o);
      end
      n_cmp++;
      if ({bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o} !== '0) begin
         n_err++;
         $display("FAIL reset_data: got A=(%0d,%0d) B=(%0d,%0d) want all 0",
                  bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o);
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (bus.ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 1", bus.ready_o);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_unscaled();
`ifdef BFLY_HALF_SCALE_EN
      send_one("basic", 1000, 0, 200, 0, TWID_ONE, 0, 600, 0, 400, 0);
`else
      send_one("basic", 1000, 0, 200, 0, TWID_ONE, 0, 1200, 0, 800, 0);
`endif
   endtask

   task automatic test_conjugate();
`ifdef BFLY_HALF_SCALE_EN
      send_one("conj", 1000, 0, 200, 0, 0, TWID_ONE, 600, 0, 0, -400);
`else
      send_one("conj", 1000, 0, 200, 0, 0, TWID_ONE, 1200, 0, 0, -800);
`endif
   endtask

   task automatic test_rounding();
`ifdef BFLY_HALF_SCALE_EN
      send_one("round_neg", 3, -3, 0, 0, TWID_ONE, 0, 2, -1, 2, -1);
      send_one("round_one", 1, 0, 0, 0, TWID_ONE, 0, 1, 0, 1, 0);
`else
      send_one("round_neg", 3, -3, 0, 0, TWID_ONE, 0, 3, -3, 3, -3);
      send_one("round_one", 1, 0, 0, 0, TWID_ONE, 0, 1, 0, 1, 0);
`endif
   endtask

   task automatic test_backpressure();
      longint ops[5][6];
      int k  = 0;
      int n0 = n_out;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 4; j++) ops[i][j] = longint'($urandom_range(0, 4000)) - 2000 + i;
         ops[i][4] = rnd_twid();
         ops[i][5] = rnd_twid();
      end
      for (int c = 0; c < 20; c++) begin
         bus.ready_i = !(c >= 4 && c < 7);
         if (k < 5) begin
            set_ops(ops[k][0], ops[k][1], ops[k][2], ops[k][3], ops[k][4], ops[k][5]);
            bus.valid_i = 1'b1;
         end else begin
            bus.valid_i = 1'b0;
         end
         #1;
         if (c >= 4 && c < 7) begin
            n_cmp++;
            if (bus.ready_o !== 1'b0) begin
               n_err++;
               $display("FAIL bp_stall_ready: cycle %0d got %b want 0", c, bus.ready_o);
            end
         end
         tick();
         if (last_acc) k++;
      end
      n_cmp++;
      if (n_out - n0 != 5 || exp_q.size() != 0 || k != 5) begin
         n_err++;
         $display("FAIL bp_count: got %0d out, %0d pending, %0d accepted want 5, 0, 5",
                  n_out - n0, exp_q.size(), k);
      end
   endtask

   task automatic test_reset_mid();
      bus.ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_ops(rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_twid(), rnd_twid());
         bus.valid_i = 1'b1;
         tick();
      end
      bus.valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_valid: got %b want 0", bus.valid_o);
      end
      n_cmp++;
      if ({bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o} !== '0) begin
         n_err++;
         $display("FAIL midreset_data: got A=(%0d,%0d) B=(%0d,%0d) want all 0",
                  bus.a_re_o, bus.a_im_o, bus.b_re_o, bus.b_im_o);
      end
      exp_q.delete();
      hold_prev = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus.valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_stale: cycle %0d got valid %b want 0", i, bus.valid_o);
         end
         tick();
      end
`ifdef BFLY_HALF_SCALE_EN
      send_one("after_reset", 1000, 0, 200, 0, TWID_ONE, 0, 600, 0, 400, 0);
`else
      send_one("after_reset", 1000, 0, 200, 0, TWID_ONE, 0, 1200, 0, 800, 0);
`endif
   endtask

   task automatic test_random();
      int acc = 0;
      int cyc = 0;
      while (acc < 10000 && cyc < 40000) begin
         bus.ready_i = ($urandom_range(0, 3) != 0);
         bus.valid_i = ($urandom_range(0, 3) != 0);
         set_ops(rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_twid(), rnd_twid());
         tick();
         if (last_acc) acc++;
         cyc++;
      end
      n_cmp++;
      if (acc < 10000) begin
         n_err++;
         $display("FAIL random_budget: got %0d accepted want 10000", acc);
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      repeat (6) tick();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL random_drain: got %0d pending want 0", exp_q.size());
      end
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      set_ops(0, 0, 0, 0, 0, 0);
      test_reset();
      test_unscaled();
      test_conjugate();
      test_rounding();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ifft_dif_butterfly_pipe.md
Name: ifft_dif_butterfly_pipe

Overview:
- Pipelined radix-2 decimation-in-frequency (Gentleman-Sande) butterfly for the inverse FFT path. It is the counterpart of the forward DIT butterfly.
- Computes A = a + b and B = (a - b) * conj(W).
- Sits between the IFFT stage memory read and write-back. Streams one butterfly per cycle under a valid/ready handshake.

Parameters:
- DATA_WIDTH, 21, signed width of all complex components (in, out, twiddle).
- FRAC_BITS, 15, fractional bits of the twiddle; Q1.15, so 1.0 = 32768.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  input operand set valid.
- ready_o  out  1  block can accept input this cycle.
- a_re_i, a_im_i  in  DATA_WIDTH  signed operand a.
- b_re_i, b_im_i  in  DATA_WIDTH  signed operand b.
- twid_re_i, twid_im_i  in  DATA_WIDTH  signed forward twiddle W; the block conjugates it internally.
- valid_o  out  1  outputs valid.
- ready_i  in  1  downstream accepts output.
- a_re_o, a_im_o  out  DATA_WIDTH  signed A result.
- b_re_o, b_im_o  out  DATA_WIDTH  signed B result.

Behaviour:
- One clock (clk_i). Reset is asynchronous, active-low (rst_ni). On assertion:
  - all stage valid flags are 0, so valid_o = 0;
  - all data registers are 0, so all data outputs = 0;
  - ready_o = 1 once reset is released.
- Three register stages, latency 3 cycles from an accepted input (valid_i && ready_o) to valid_o.
  - S1: register sum s = a+b and diff d = a-b (DATA_WIDTH+1 bits each), plus the twiddle.
  - S2: register the four products d_re*w_re, d_im*w_im, d_im*w_re, d_re*w_im (2*DATA_WIDTH+1 bits each).
  - S3: combine, round, shift, truncate; register the outputs.
- Conjugate multiply:
  - re = d_re*w_re + d_im*w_im
  - im = d_im*w_re - d_re*w_im
- Rounding is round-half-up: add 1 << (shift-1) then arithmetic shift right. The result is truncated (wrap, no saturation) to DATA_WIDTH.
- Flow control is a global stall.
  - stall = valid_o && !ready_i; ready_o = !stall.
  - During stall every stage and output register holds its value; output data must stay stable while valid_o=1 and ready_i=0.
  - When not stalled all stages advance each cycle; bubbles propagate and are not collapsed.
  - valid_i while ready_o=0 is ignored; the input is not captured.
- Throughput is 1 butterfly per cycle when ready_i is held at 1.
- Order is strictly FIFO; no reordering.
- Reset mid-operation discards in-flight data; no output is produced for it.
- Simultaneous accept and emit in the same cycle is normal streaming, with no bubble inserted.

Optional Feature:
- Macro: BFLY_HALF_SCALE_EN.
- Defined: both outputs are scaled by 1/2 per stage, giving the IFFT 1/N normalisation across log2(N) stages.
  - A = (s + 1) >>> 1.
  - B = (prod + (1 << FRAC_BITS)) >>> (FRAC_BITS+1).
- Undefined: no scaling.
  - A = s, truncated.
  - B = (prod + (1 << (FRAC_BITS-1))) >>> FRAC_BITS.

Decomposition:
- Shared package fft_pkg holds:
  - DATA_WIDTH and FRAC_BITS defaults;
  - MUL_W = 2*DATA_WIDTH;
  - constant TWID_ONE = 1 << FRAC_BITS;
  - typedef for a complex sample struct {re, im}.
- One natural sub-module: cplx_mul_conj. It holds the product register (S2) and the combine/round path, has the same stall enable, and is reusable by a future CORDIC-free rotator.

Test Plan:
- Unscaled: a=(1000,0), b=(200,0), W=(32768,0) -> 3 cycles later A=(1200,0), B=(800,0).
- Conjugate: a=(1000,0), b=(200,0), W=(0,32768) -> A=(1200,0), B=(0,-800). With BFLY_HALF_SCALE_EN: A=(600,0), B=(0,-400).
- Rounding with BFLY_HALF_SCALE_EN:
  - a=(3,-3), b=0, W=(32768,0) -> A=(2,-1), B=(2,-1).
  - a=(1,0), b=0 -> A=(1,0).
- Backpressure:
  - Stream 5 distinct inputs with ready_i=1, then drop ready_i at cycle 4 for 3 cycles -> ready_o=0 and outputs held stable during the stall.
  - After release, all 5 results emerge in order with no loss or duplicates.
- Reset mid-stream: assert rst_ni=0 with 3 items in flight -> valid_o=0 and outputs 0 immediately (asynchronous). No stale output after release; the first new input emerges exactly 3 cycles after acceptance.
- Random regression: 10k random operands with random ready_i -> bit-exact match against the reference model, both with and without the macro.
